// File: rtl/fp_multiplier_pipelined_if.sv
// Operand/result handshake bundle for fp_multiplier_pipelined.
//   in_valid/in_ready        : operand-side handshake (transfer on both high)
//   floating1_in/floating2_in: operands A and B, IEEE-754 packed
//   out_valid/out_ready      : result-side handshake (transfer on both high)
//   multi_out                : packed product
//   flags_out                : {invalid, overflow, underflow, inexact} for multi_out
// master = producer/consumer around the multiplier, slave = the multiplier.
interface fp_multiplier_pipelined_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] floating1_in;
  logic [DATA_WIDTH-1:0] floating2_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] multi_out;
  logic [3:0]            flags_out;

  modport master (
    output in_valid, floating1_in, floating2_in, out_ready,
    input  in_ready, out_valid, multi_out, flags_out
  );

  modport slave (
    input  in_valid, floating1_in, floating2_in, out_ready,
    output in_ready, out_valid, multi_out, flags_out
  );
endinterface

// File: rtl/fp_multiplier_pipelined.sv
// Parametrised IEEE-754 binary multiplier, three register stages, one result per
// clock when downstream is ready. Round-to-nearest-even, subnormal inputs treated
// as zero, underflowed results flushed to zero, per-result exception flags.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, drops every in-flight item
//   bus  : fp_multiplier_pipelined_if.slave (operand and result handshakes,
//          operands, product, flags {invalid, overflow, underflow, inexact})
// The whole pipe advances together: any stall at the output holds every stage
// and deasserts in_ready in the same cycle.
module fp_multiplier_pipelined #(
  parameter int EXPO_WIDTH = 8,
  parameter int MENT_WIDTH = 23
) (
  input logic                    clk,
  input logic                    rst,
  fp_multiplier_pipelined_if.slave bus
);

  localparam int DATA_WIDTH = 1 + EXPO_WIDTH + MENT_WIDTH;
  localparam int BIAS       = 2**(EXPO_WIDTH-1) - 1;
  localparam int EW         = EXPO_WIDTH + 2;
  localparam int MW         = MENT_WIDTH + 1;
  localparam int PW         = 2 * MW;
  localparam logic [DATA_WIDTH-1:0] QNAN =
    {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MENT_WIDTH-1){1'b0}}};

  // Normalise, round to nearest even and pack a finite non-zero product.
  // Returns {flags, packed result}.
  function automatic logic [DATA_WIDTH+3:0] round_pack(
    input logic                 sign,
    input logic signed [EW-1:0] exp_in,
    input logic [PW-1:0]        prod
  );
    logic                  top;
    logic [MENT_WIDTH-1:0] frac;
    logic                  guard;
    logic                  sticky;
    logic                  up;
    logic [MENT_WIDTH:0]   frac_r;
    logic signed [EW-1:0]  e;
    logic [3:0]            flags;
    logic [DATA_WIDTH-1:0] res;
    // Product of two [1,2) mantissas lies in [1,4): the top bit selects the window.
    top    = prod[PW-1];
    frac   = top ? prod[PW-2 -: MENT_WIDTH] : prod[PW-3 -: MENT_WIDTH];
    guard  = top ? prod[PW-MW-1] : prod[PW-MW-2];
    sticky = top ? |prod[PW-MW-2:0] : |prod[PW-MW-3:0];
    e      = exp_in + EW'(top);
    up     = guard && (sticky || frac[0]);
    frac_r = {1'b0, frac} + (MENT_WIDTH+1)'(up);
    // Fraction overflow means the mantissa rolled to 2.0: fraction is already 0.
    if (frac_r[MENT_WIDTH]) e = e + EW'(1);
    if (e >= EW'(2**EXPO_WIDTH - 1)) begin
      flags = 4'b0101;
      res   = {sign, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
    end else if (e <= EW'(0)) begin
      flags = 4'b0011;
      res   = {sign, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      flags = {3'b000, guard | sticky};
      res   = {sign, e[EXPO_WIDTH-1:0], frac_r[MENT_WIDTH-1:0]};
    end
    return {flags, res};
  endfunction

  logic adv;
  logic vld_p0, vld_p1, vld_p2;

  assign adv          = !vld_p2 || bus.out_ready;
  assign bus.in_ready = adv;

  // Unpack and classify the incoming operands
  logic [EXPO_WIDTH-1:0] ea, eb;
  logic [MENT_WIDTH-1:0] fa, fb;
  logic                  za, zb, ia, ib, na, nb;
  logic                  nan_s, inv_s, inf_s, zero_s;
  logic signed [EW-1:0]  exp_sum_s;

  assign ea = bus.floating1_in[DATA_WIDTH-2 -: EXPO_WIDTH];
  assign eb = bus.floating2_in[DATA_WIDTH-2 -: EXPO_WIDTH];
  assign fa = bus.floating1_in[MENT_WIDTH-1:0];
  assign fb = bus.floating2_in[MENT_WIDTH-1:0];
  // Exponent 0 is zero whatever the fraction: subnormals are flushed on input.
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (&ea) && (fa == '0);
  assign ib = (&eb) && (fb == '0);
  assign na = (&ea) && (|fa);
  assign nb = (&eb) && (|fb);
  // Special outcomes are resolved here in precedence order so later stages
  // only see one-hot overrides.
  assign nan_s     = na | nb;
  assign inv_s     = !nan_s && ((ia && zb) || (za && ib));
  assign inf_s     = !nan_s && !inv_s && (ia || ib);
  assign zero_s    = !nan_s && !inv_s && !inf_s && (za || zb);
  assign exp_sum_s = EW'(ea) + EW'(eb) - EW'(BIAS);

  logic                 sign_p0, nan_p0, inv_p0, inf_p0, zero_p0;
  logic signed [EW-1:0] exp_p0;
  logic [MW-1:0]        ma_p0, mb_p0;

  logic                 sign_p1, nan_p1, inv_p1, inf_p1, zero_p1;
  logic signed [EW-1:0] exp_p1;
  logic [PW-1:0]        prod_p1;

  logic [DATA_WIDTH-1:0] res_p2;
  logic [3:0]            flags_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= bus.in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // p0 -> p1: unpacked operands captured, mantissa product formed
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p0 <= bus.floating1_in[DATA_WIDTH-1] ^ bus.floating2_in[DATA_WIDTH-1];
      nan_p0  <= nan_s;
      inv_p0  <= inv_s;
      inf_p0  <= inf_s;
      zero_p0 <= zero_s;
      exp_p0  <= exp_sum_s;
      ma_p0   <= {1'b1, fa};
      mb_p0   <= {1'b1, fb};

      sign_p1 <= sign_p0;
      nan_p1  <= nan_p0;
      inv_p1  <= inv_p0;
      inf_p1  <= inf_p0;
      zero_p1 <= zero_p0;
      exp_p1  <= exp_p0;
      prod_p1 <= PW'(ma_p0) * PW'(mb_p0);
    end
  end

  // p1 -> p2: normalise/round/pack, specials override the arithmetic
  logic [DATA_WIDTH+3:0] word_s3;

  always_comb begin
    word_s3 = round_pack(sign_p1, exp_p1, prod_p1);
    if (nan_p1) begin
      word_s3 = {4'b0000, QNAN};
    end else if (inv_p1) begin
      word_s3 = {4'b1000, QNAN};
    end else if (inf_p1) begin
      word_s3 = {4'b0000, sign_p1, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
    end else if (zero_p1) begin
      word_s3 = {4'b0000, sign_p1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p2   <= '0;
      flags_p2 <= '0;
    end else if (adv && vld_p1) begin
      {flags_p2, res_p2} <= word_s3;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.multi_out = res_p2;
  assign bus.flags_out = flags_p2;

endmodule

// File: tb/tb_fp_multiplier_pipelined.sv
// Bench for fp_multiplier_pipelined (binary32 configuration). A reference model
// computes each expected {flags, product} from exact integer arithmetic; a
// scoreboard queue orders expectations by acceptance and is compared against
// every result handed downstream. Directed cases cover the corner values,
// backpressure and mid-flight reset; the bulk is randomized.
module tb_fp_multiplier_pipelined;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_multiplier_pipelined_if #(.DATA_WIDTH(32)) bus ();

  fp_multiplier_pipelined dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int out_cnt     = 0;

  logic [35:0] exp_q[$];
  logic [31:0] opa[$];
  logic [31:0] opb[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Exact product rounded to nearest-even by integer division; returns {flags, result}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    longint unsigned fa, fb, p, q, r, half;
    logic s, za, zb, ia, ib, na, nb, inx;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = {41'd0, a[22:0]};
    fb = {41'd0, b[22:0]};
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    if (na || nb) return {4'b0000, 32'h7FC00000};
    if ((ia && zb) || (za && ib)) return {4'b1000, 32'h7FC00000};
    if (ia || ib) return {4'b0000, s, 8'hFF, 23'd0};
    if (za || zb) return {4'b0000, s, 31'd0};
    p = (fa + 64'd8388608) * (fb + 64'd8388608);
    e = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    r    = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inx  = (r != 0);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0011, s, 31'd0};
    return {3'b000, inx, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] t;
    logic [7:0]  e;
    logic [22:0] f;
    t = $urandom;
    f = t[22:0];
    case ($urandom_range(0, 7))
      0, 1, 2: e = 8'($urandom_range(100, 154));
      3:       e = 8'($urandom_range(1, 20));
      4:       e = 8'($urandom_range(235, 254));
      5: begin
        case ($urandom_range(0, 4))
          0:       e = 8'd0;
          1: begin e = 8'd255; f = 23'd0; end
          2: begin e = 8'd255; f = f | 23'd1; end
          3: begin e = 8'd0;   f = 23'd0; end
          default: begin e = 8'd127; f = 23'd0; end
        endcase
      end
      6: begin
        e = 8'($urandom_range(1, 254));
        f = 23'h7FFFFF ^ 23'($urandom_range(0, 3));
      end
      default: return $urandom;
    endcase
    return {t[31], e, f};
  endfunction

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle", {63'd0, bus.out_valid}, 64'd0);
  endtask

  task automatic stream(input bit rnd);
    int budget = 20000;
    while (opa.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      bus.in_valid     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.floating1_in = opa[0];
      bus.floating2_in = opb[0];
      bus.out_ready    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        void'(opa.pop_front());
        void'(opb.pop_front());
      end
      budget--;
    end
    check("stream_budget", {63'd0, budget > 0}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
  endtask

  task automatic measure(input logic [31:0] a, input logic [31:0] b, output int lat);
    @(posedge clk); #1;
    bus.in_valid     = 1'b1;
    bus.floating1_in = a;
    bus.floating2_in = b;
    bus.out_ready    = 1'b1;
    @(negedge clk);
    check("lat_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int acc;
    int base;
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.floating1_in = '0;
    bus.floating2_in = '0;
    bus.out_ready    = 1'b0;

    fork
      begin
        logic [35:0] held_val;
        logic [35:0] e;
        bit          held;
        held = 1'b0;
        held_val = '0;
        forever begin
          @(negedge clk);
          if (rst) begin
            exp_q.delete();
            held = 1'b0;
          end else begin
            if (held)
              check("stall_stable", {27'd0, bus.out_valid, bus.flags_out, bus.multi_out},
                    {27'd0, 1'b1, held_val});
            if (bus.in_valid && bus.in_ready)
              exp_q.push_back(model(bus.floating1_in, bus.floating2_in));
            if (bus.out_valid && bus.out_ready) begin
              if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_output: got %0h, expected no result", {bus.flags_out, bus.multi_out});
              end else begin
                e = exp_q.pop_front();
                check("result", {28'd0, bus.flags_out, bus.multi_out}, {28'd0, e});
                out_cnt++;
              end
            end
            held     = bus.out_valid && !bus.out_ready;
            held_val = {bus.flags_out, bus.multi_out};
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_multi_out", {32'd0, bus.multi_out}, 64'd0);
    check("rst_flags_out", {60'd0, bus.flags_out}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Hand-computed expectations pinning the reference model
    check("model_1p5x2",    {28'd0, model(32'h3FC00000, 32'h40000000)}, {28'd0, 4'b0000, 32'h40400000});
    check("model_rne_up",   {28'd0, model(32'h3F800001, 32'h3F800001)}, {28'd0, 4'b0001, 32'h3F800002});
    check("model_tie_even", {28'd0, model(32'h3FFFF000, 32'h3FFFF800)}, {28'd0, 4'b0001, 32'h407FE800});
    check("model_ovf",      {28'd0, model(32'h7F000000, 32'h40000000)}, {28'd0, 4'b0101, 32'h7F800000});
    check("model_unf",      {28'd0, model(32'h00800000, 32'h3F000000)}, {28'd0, 4'b0011, 32'h00000000});
    check("model_inf_zero", {28'd0, model(32'h7F800000, 32'h00000000)}, {28'd0, 4'b1000, 32'h7FC00000});
    check("model_ninf",     {28'd0, model(32'hFF800000, 32'h40000000)}, {28'd0, 4'b0000, 32'hFF800000});
    check("model_nan",      {28'd0, model(32'h7FA00000, 32'h3F800000)}, {28'd0, 4'b0000, 32'h7FC00000});
    check("model_nzero",    {28'd0, model(32'h80000000, 32'h40000000)}, {28'd0, 4'b0000, 32'h80000000});

    // Latency of the first transaction
    measure(32'h3FC00000, 32'h40000000, lat);
    check("latency_first", 64'(lat), 64'd3);
    check("first_product", {28'd0, bus.flags_out, bus.multi_out}, {28'd0, 4'b0000, 32'h40400000});
    drain();

    // Directed corner values through the pipe
    opa = '{32'h3F800001, 32'h3FFFF000, 32'h7F000000, 32'h00800000, 32'h7F800000,
            32'hFF800000, 32'h7FA00000, 32'h80000000, 32'h00000001, 32'h3FFFF800};
    opb = '{32'h3F800001, 32'h3FFFF800, 32'h40000000, 32'h3F000000, 32'h00000000,
            32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3FFFF000};
    stream(1'b0);

    // Backpressure: out_ready dropped from the fourth cycle
    for (int i = 0; i < 6; i++) begin
      opa.push_back(rand_op());
      opb.push_back(rand_op());
    end
    acc  = 0;
    base = out_cnt;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      bus.in_valid     = (opa.size() != 0);
      bus.floating1_in = opa[0];
      bus.floating2_in = opb[0];
      bus.out_ready    = (c < 3);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        void'(opa.pop_front());
        void'(opb.pop_front());
        acc++;
      end
    end
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
    stream(1'b0);
    check("bp_all_out", 64'(out_cnt - base), 64'd6);

    // Reset with items in flight
    @(posedge clk); #1;
    bus.in_valid     = 1'b1;
    bus.floating1_in = 32'h3FC00000;
    bus.floating2_in = 32'h40000000;
    bus.out_ready    = 1'b1;
    @(posedge clk); #1;
    bus.floating1_in = 32'h40400000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_valid", {63'd0, bus.out_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_async_data", {28'd0, bus.flags_out, bus.multi_out}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_no_stale", {63'd0, bus.out_valid}, 64'd0);
    measure(32'h40400000, 32'h40000000, lat);
    check("latency_after_rst", 64'(lat), 64'd3);
    drain();

    // Randomized traffic with random gaps and backpressure
    for (int i = 0; i < 400; i++) begin
      opa.push_back(rand_op());
      opb.push_back(rand_op());
    end
    stream(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
